// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 demux scheduler.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // One-hot channel vector for a channel index.
    function automatic logic [NUM_CH-1:0] onehot_ch(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters.
// Ports:
//   req_i   - request mask, bit k = channel k
//   last_i  - previously granted channel; search starts strictly after it
//   gnt_c   - granted channel index (valid when any_c = 1)
//   any_c   - at least one request present
module rr_pick4
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  last_i,
    output logic [SEL_W-1:0]  gnt_c,
    output logic              any_c
);

    logic [SEL_W-1:0] idx;

    // Scan from farthest (last_i itself) to nearest (last_i+1) so the nearest wins.
    always_comb begin
        gnt_c = last_i;
        any_c = 1'b0;
        idx   = last_i;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = last_i + SEL_W'(k);
            if (req_i[idx]) begin
                gnt_c = idx;
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux4_rr_scheduler.sv
// Registered 1:4 demux controller: accepts words on a valid/ready input,
// steers each to one channel chosen by round-robin or fixed select, holds it
// until the channel accepts it, and counts completed transfers.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   in_valid/in_data       - input word
//   in_ready               - combinational: a word can be taken this cycle
//   ch_en, mode, fix_sel   - channel enable mask, 0=RR/1=fixed, fixed channel
//   out_ready              - per-channel accept
//   out_valid/out_data/sel - registered one-hot offer, word, channel index
//   xfer_cnt               - completed transfers, wraps
module demux4_rr_scheduler
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    fix_sel,
    input  logic [NUM_CH-1:0]   out_ready,
    output logic [NUM_CH-1:0]   out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    xfer_cnt
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   valid_q, valid_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0]    rr_gnt_c;
    logic                rr_any_c;
    logic [SEL_W-1:0]    pick_c;
    logic                eligible_c;
    logic                fire_c;
    logic                accept_c;

    rr_pick4 u_rr_pick4 (
        .req_i  (ch_en),
        .last_i (rr_ptr_q),
        .gnt_c  (rr_gnt_c),
        .any_c  (rr_any_c)
    );

    // Channel choice for a word accepted this cycle; out_ready plays no part.
    always_comb begin
        pick_c     = rr_gnt_c;
        eligible_c = rr_any_c;
        if (mode == MODE_FIX) begin
            pick_c     = fix_sel;
            eligible_c = ch_en[fix_sel];
        end
    end

    // Fire uses the latched channel so mid-hold config changes cannot redirect it.
    always_comb begin
        fire_c   = (state_q == ST_HOLD) && out_ready[sel_q];
        in_ready = eligible_c && ((state_q == ST_EMPTY) || fire_c);
        accept_c = in_valid && in_ready;
    end

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;

        if (fire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept_c) begin
            state_d = ST_HOLD;
            data_d  = in_data;
            sel_d   = pick_c;
            valid_d = onehot_ch(pick_c);
            if (mode == MODE_RR) begin
                rr_ptr_d = pick_c;
            end
        end else if (fire_c) begin
            state_d = ST_EMPTY;
            valid_d = '0;
        end
    end

    // State registers; rr_ptr resets to 3 so the first RR pick is channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            sel_q    <= '0;
            valid_q  <= '0;
            rr_ptr_q <= SEL_W'(3);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign xfer_cnt  = cnt_q;

endmodule
